// File: rtl/ahb_cmd_master.sv
// ahb_cmd_master: AHB-Lite initiator converting a valid/ready command stream
// into single NONSEQ transfers, returning one in-order response per command.
//
// Ports:
//   HCLK, HRESETn                   clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_addr/write/size/wdata       command payload (wdata right-aligned)
//   resp_valid/resp_rdata/resp_err  one-cycle response pulse, no backpressure
//   HADDR/HTRANS/HSIZE/HWRITE/HWDATA/HPROT  AHB-Lite master outputs
//   HRDATA/HREADY/HRESP             AHB-Lite slave returns
//
// Build option: define AHB_MASTER_PIPELINE_EN to overlap the address phase of
// command N+1 with the data phase of command N (one transfer per cycle).
// Without it, transfers are separated by at least one IDLE cycle.
module ahb_cmd_master (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_addr,
    input  logic        cmd_write,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [3:0]  HPROT,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [3:0] HPROT_VAL     = 4'b0011;

    // address-phase slot
    logic        ap_valid;
    logic [31:0] ap_addr;
    logic [2:0]  ap_size;
    logic        ap_write;
    logic [31:0] ap_wdata;

    // data-phase slot
    logic        dp_valid;
    logic [1:0]  dp_lane;
    logic [2:0]  dp_size;
    logic        dp_write;

    logic [31:0] hwdata_q;
    logic        resp_valid_q;
    logic [31:0] resp_rdata_q;
    logic        resp_err_q;

    logic        cmd_bad_c;
    logic        ready_good_c;
    logic        ready_bad_c;
    logic        acc_good_c;
    logic        acc_bad_c;
    logic        dp_done_c;

    // Replicate right-aligned write data across all byte lanes.
    function automatic logic [31:0] lane_replicate(input logic [31:0] w, input logic [2:0] size);
        case (size)
            3'd0:    return {4{w[7:0]}};
            3'd1:    return {2{w[15:0]}};
            default: return w;
        endcase
    endfunction

    // Pull the addressed lanes down to bit 0 and zero-extend to the size.
    function automatic logic [31:0] lane_extract(input logic [31:0] d, input logic [1:0] lane,
                                                 input logic [2:0] size);
        logic [31:0] s;
        s = d >> {lane, 3'b000};
        case (size)
            3'd0:    return {24'h0, s[7:0]};
            3'd1:    return {16'h0, s[15:0]};
            default: return s;
        endcase
    endfunction

    // Illegal size or misaligned address never reaches the bus.
    always_comb begin
        cmd_bad_c = 1'b0;
        case (cmd_size)
            3'd0:    cmd_bad_c = 1'b0;
            3'd1:    cmd_bad_c = cmd_addr[0];
            3'd2:    cmd_bad_c = |cmd_addr[1:0];
            default: cmd_bad_c = 1'b1;
        endcase
    end

`ifdef AHB_MASTER_PIPELINE_EN
    assign ready_good_c = !ap_valid || HREADY;
`else
    assign ready_good_c = !ap_valid && (!dp_valid || HREADY);
`endif
    // Rejected commands wait for an empty pipe so their response stays in order.
    assign ready_bad_c = !ap_valid && !dp_valid;
    assign cmd_ready   = HRESETn && (cmd_bad_c ? ready_bad_c : ready_good_c);
    assign acc_good_c  = cmd_valid && cmd_ready && !cmd_bad_c;
    assign acc_bad_c   = cmd_valid && cmd_ready && cmd_bad_c;
    assign dp_done_c   = dp_valid && HREADY;

    // Pipeline slots, write-data lanes and response register.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            ap_valid     <= 1'b0;
            ap_addr      <= 32'h0;
            ap_size      <= 3'd0;
            ap_write     <= 1'b0;
            ap_wdata     <= 32'h0;
            dp_valid     <= 1'b0;
            dp_lane      <= 2'd0;
            dp_size      <= 3'd0;
            dp_write     <= 1'b0;
            hwdata_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            if (HREADY) begin
                dp_valid <= ap_valid;
                if (ap_valid) begin
                    dp_lane  <= ap_addr[1:0];
                    dp_size  <= ap_size;
                    dp_write <= ap_write;
                    hwdata_q <= lane_replicate(ap_wdata, ap_size);
                end
            end

            // A stalled address phase is never overwritten: acceptance needs
            // either an empty slot or HREADY moving the slot on this edge.
            if (acc_good_c) begin
                ap_valid <= 1'b1;
                ap_addr  <= cmd_addr;
                ap_size  <= cmd_size;
                ap_write <= cmd_write;
                ap_wdata <= cmd_wdata;
            end else if (HREADY) begin
                ap_valid <= 1'b0;
            end

            resp_valid_q <= dp_done_c || acc_bad_c;
            if (dp_done_c) begin
                resp_err_q   <= HRESP;
                resp_rdata_q <= dp_write ? 32'h0 : lane_extract(HRDATA, dp_lane, dp_size);
            end else begin
                resp_err_q   <= acc_bad_c;
                resp_rdata_q <= 32'h0;
            end
        end
    end

    assign HTRANS     = ap_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR      = ap_addr;
    assign HSIZE      = ap_size;
    assign HWRITE     = ap_write;
    assign HWDATA     = hwdata_q;
    assign HPROT      = HPROT_VAL;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule
